// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: per-stage payload
// layouts and the stage occupancy encoding.
package pipe_pkg;

    // ID->EX payload layout: {instr, pc}, with pc in the low word.
    localparam int unsigned ID_EX_W     = 64;
    localparam int unsigned EX_PC_LSB   = 0;
    localparam int unsigned EX_PC_W     = 32;
    localparam int unsigned EX_INSN_LSB = 32;
    localparam int unsigned EX_INSN_W   = 32;
    localparam logic [ID_EX_W-1:0] EX_PC_RESET = 64'h0000_0000_7fff_fffc;

    typedef struct packed {
        logic [EX_INSN_W-1:0] instr;
        logic [EX_PC_W-1:0]   pc;
    } id_ex_t;

    // Stage occupancy: no entry, main entry only, main + skid entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance accounting.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset, clears the count
//   clr - synchronous clear
//   inc - add one this cycle unless already all-ones
//   cnt - current count
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and an
// optional two-entry skid buffer that registers in_ready.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop all held entries next cycle
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload
//   stall_cnt           - saturating count of out_valid & ~out_ready cycles
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W     = 64,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0,
    parameter bit                 SKID       = 1'b1,
    parameter int unsigned        CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    if (SKID) begin : g_skid
        logic [1:0]        state;
        logic [1:0]        state_nxt;
        logic [DATA_W-1:0] main_q;
        logic [DATA_W-1:0] main_nxt;
        logic [DATA_W-1:0] skid_q;
        logic [DATA_W-1:0] skid_nxt;
        logic              valid_q;
        logic              ready_q;
        logic              in_fire;
        logic              out_fire;

        assign in_fire  = in_valid & ready_q;
        assign out_fire = valid_q & out_ready;

        // State and data registers; out_valid/in_ready are re-derived from
        // the next state so neither depends combinationally on out_ready.
        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= ST_EMPTY;
                main_q  <= RESET_DATA;
                skid_q  <= RESET_DATA;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                state   <= state_nxt;
                main_q  <= main_nxt;
                skid_q  <= skid_nxt;
                valid_q <= (state_nxt != ST_EMPTY);
                ready_q <= (state_nxt != ST_SKID);
            end
        end

        // Next-state and data steering.
        always_comb begin
            state_nxt = state;
            main_nxt  = main_q;
            skid_nxt  = skid_q;
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_FULL;
                        main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt = ST_SKID;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_nxt = ST_FULL;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
            // Flush discards both entries, including anything accepted now.
            if (flush) begin
                state_nxt = ST_EMPTY;
                main_nxt  = RESET_DATA;
                skid_nxt  = RESET_DATA;
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = valid_q;
        assign out_data  = main_q;
    end else begin : g_bare
        logic              valid_q;
        logic [DATA_W-1:0] data_q;
        logic              in_fire;
        logic              out_fire;

        // Accept whenever the register is empty or drains this cycle.
        assign in_ready = ~valid_q | out_ready;
        assign in_fire  = in_valid & in_ready;
        assign out_fire = valid_q & out_ready;

        // Single register; out_data holds its value after draining.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_q <= 1'b0;
                data_q  <= RESET_DATA;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (out_valid & ~out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-register
// instance (4-bit stall counter), both checked every cycle against a queue
// scoreboard of the entries the stage should currently hold.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [63:0] S_RST = EX_PC_RESET;
    localparam logic [63:0] B_RST = 64'h0000_0000_0000_5a5a;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [63:0] s_in_data, s_out_data;
    logic [31:0] s_stall;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [3:0]  b_stall;

    pipe_stage_reg #(.DATA_W(64), .RESET_DATA(S_RST), .SKID(1'b1), .CNT_W(32)) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall)
    );

    pipe_stage_reg #(.DATA_W(64), .RESET_DATA(B_RST), .SKID(1'b0), .CNT_W(4)) u_bare (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    logic [63:0] s_q[$];
    logic [63:0] b_q[$];
    logic [63:0] s_held, b_held;
    logic [31:0] s_mcnt;
    logic [3:0]  b_mcnt;
    bit          s_acc, b_acc;
    logic [31:0] base;
    int          n;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Skid stage model: holds up to two entries, in_ready = fewer than two.
    task automatic model_skid();
        bit ev, er, ofire, ifire;
        ev = (s_q.size() > 0);
        er = (s_q.size() < 2);
        check_eq("s_out_valid", 64'(s_out_valid), 64'(ev));
        check_eq("s_in_ready", 64'(s_in_ready), 64'(er));
        check_eq("s_out_data", s_out_data, s_held);
        check_eq("s_stall", 64'(s_stall), 64'(s_mcnt));
        ofire = ev & s_out_ready;
        ifire = s_in_valid & er;
        s_acc = ifire;
        if (rst) begin
            s_q.delete(); s_held = S_RST; s_mcnt = '0; s_acc = 1'b0;
        end else begin
            if (ev && !s_out_ready && s_mcnt != '1) s_mcnt = s_mcnt + 32'd1;
            if (ofire) void'(s_q.pop_front());
            if (s_flush) begin
                s_q.delete(); s_held = S_RST;
            end else begin
                if (ifire) s_q.push_back(s_in_data);
                if (s_q.size() > 0) s_held = s_q[0];
            end
        end
    endtask

    // Single-register model: in_ready = empty or draining this cycle.
    task automatic model_bare();
        bit ev, er, ofire, ifire;
        ev = (b_q.size() > 0);
        er = !ev || b_out_ready;
        check_eq("b_out_valid", 64'(b_out_valid), 64'(ev));
        check_eq("b_in_ready", 64'(b_in_ready), 64'(er));
        check_eq("b_out_data", b_out_data, b_held);
        check_eq("b_stall", 64'(b_stall), 64'(b_mcnt));
        ofire = ev & b_out_ready;
        ifire = b_in_valid & er;
        b_acc = ifire;
        if (rst) begin
            b_q.delete(); b_held = B_RST; b_mcnt = '0; b_acc = 1'b0;
        end else begin
            if (ev && !b_out_ready && b_mcnt != '1) b_mcnt = b_mcnt + 4'd1;
            if (ofire) void'(b_q.pop_front());
            if (b_flush) begin
                b_q.delete(); b_held = B_RST;
            end else begin
                if (ifire) b_q.push_back(b_in_data);
                if (b_q.size() > 0) b_held = b_q[0];
            end
        end
    endtask

    // One clock: check at the falling edge, then return 1 after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (chk_en) begin
            model_skid();
            model_bare();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_flush = 0; s_in_valid = 0; s_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        s_in_data = '0; b_in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        s_held = S_RST; b_held = B_RST; s_mcnt = '0; b_mcnt = '0;
        chk_en = 1'b1;

        // Reset state
        cycle();
        check_eq("rst_s_out_valid", 64'(s_out_valid), 64'd0);
        check_eq("rst_s_out_data", s_out_data, 64'h7ffffffc);
        check_eq("rst_s_in_ready", 64'(s_in_ready), 64'd1);
        check_eq("rst_s_stall", 64'(s_stall), 64'd0);
        rst = 1'b0;

        // Streaming 1..100 at full throughput on both instances
        s_out_ready = 1; b_out_ready = 1;
        s_in_valid = 1; b_in_valid = 1;
        s_in_data = 64'd1; b_in_data = 64'd1;
        n = 0;
        for (int i = 0; i < 300 && (s_in_valid || b_in_valid); i++) begin
            cycle();
            n++;
            if (s_acc) s_in_data = s_in_data + 64'd1;
            if (b_acc) b_in_data = b_in_data + 64'd1;
            if (s_in_data > 64'd100) s_in_valid = 0;
            if (b_in_data > 64'd100) b_in_valid = 0;
        end
        check_eq("stream_cycles", 64'(n), 64'd100);
        repeat (3) cycle();

        // Backpressure into the skid entry
        base = s_mcnt;
        s_out_ready = 0; s_in_valid = 1; s_in_data = 64'hA;
        cycle();
        s_in_data = 64'hB;
        cycle();
        s_in_valid = 0;
        check_eq("bp_in_ready_low", 64'(s_in_ready), 64'd0);
        repeat (3) cycle();
        check_eq("bp_stall", 64'(s_stall), 64'(base + 32'd4));
        check_eq("bp_head", s_out_data, 64'hA);
        s_out_ready = 1;
        cycle();
        check_eq("bp_second", s_out_data, 64'hB);
        check_eq("bp_second_valid", 64'(s_out_valid), 64'd1);
        cycle();
        check_eq("bp_drained", 64'(s_out_valid), 64'd0);

        // Flush while holding two entries, with a new item offered
        s_out_ready = 0; s_in_valid = 1; s_in_data = 64'hC;
        cycle();
        s_in_data = 64'hD;
        cycle();
        s_in_data = 64'hE; s_flush = 1;
        cycle();
        s_flush = 0; s_in_valid = 0;
        check_eq("fl_out_valid", 64'(s_out_valid), 64'd0);
        check_eq("fl_out_data", s_out_data, S_RST);
        check_eq("fl_in_ready", 64'(s_in_ready), 64'd1);
        s_out_ready = 1;
        repeat (3) cycle();

        // Flush in FULL while an input is actually accepted: item is dropped
        s_out_ready = 0; s_in_valid = 1; s_in_data = 64'hF;
        cycle();
        s_in_data = 64'h10; s_flush = 1;
        cycle();
        s_flush = 0; s_in_valid = 0;
        check_eq("fl2_out_valid", 64'(s_out_valid), 64'd0);
        s_out_ready = 1;
        repeat (2) cycle();

        // Single register with alternating backpressure
        b_in_valid = 1; b_in_data = 64'd200;
        for (int i = 0; i < 40; i++) begin
            b_out_ready = i[0];
            cycle();
            if (b_acc) b_in_data = b_in_data + 64'd1;
        end
        // Combinational in_ready while holding an entry
        b_in_valid = 0; b_out_ready = 0;
        cycle();
        b_out_ready = 0;
        #1 check_eq("comb_ready_lo", 64'(b_in_ready), 64'd0);
        b_out_ready = 1;
        #1 check_eq("comb_ready_hi", 64'(b_in_ready), 64'd1);
        repeat (2) cycle();

        // Random traffic with occasional flush on both instances
        for (int i = 0; i < 300; i++) begin
            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_out_ready = ($urandom_range(0, 2) != 0);
            s_flush     = ($urandom_range(0, 15) == 0);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 15) == 0);
            cycle();
            if (s_acc) s_in_data = s_in_data + 64'd1;
            if (b_acc) b_in_data = b_in_data + 64'd1;
        end
        idle_inputs();

        // Saturation of the 4-bit counter
        rst = 1;
        cycle();
        rst = 0;
        b_out_ready = 0; b_in_valid = 1; b_in_data = 64'd300;
        repeat (22) cycle();
        check_eq("sat_15", 64'(b_stall), 64'd15);
        b_in_valid = 0; b_flush = 1;
        cycle();
        b_flush = 0;
        repeat (2) cycle();
        check_eq("sat_after_flush", 64'(b_stall), 64'd15);
        rst = 1;
        cycle();
        rst = 0;
        check_eq("sat_after_rst", 64'(b_stall), 64'd0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
